agex_branch_resolve: RTL
========================

# agex_branch_resolve

Branch resolution unit in the AGEX stage. It is the producing end of the AGEX-to-FE predictor-update and redirect bundle. Per valid control-flow instruction it computes the actual outcome and next PC, compares them against the prediction carried down from FE, and drives registered redirect and BTB/PHT/BHR update pulses back to FE. It also squashes the single wrong-path instruction that reaches AGEX during the redirect cycle and keeps branch/mispredict statistics.

## Interface
Parameters:
- DBITS, 32: data/PC width
- PHT_IDX_BITS, 8: PHT index width carried with each instruction
- CNT_BITS, 32: statistics counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- valid_i  in  1  AGEX latch holds a valid instruction
- stall_i  in  1  AGEX held this cycle; the same instruction is presented again next cycle
- br_op_i  in  4  NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR
- rs1_i, rs2_i  in  DBITS  operand values
- imm_i  in  DBITS  sign-extended immediate
- pc_i, pcplus_i  in  DBITS  instruction PC and PC+4
- pht_index_i  in  PHT_IDX_BITS  PHT index captured in FE
- pred_next_pc_i  in  DBITS  next PC predicted by FE
- br_mispred_o  out  1  redirect FE
- br_target_o  out  DBITS  correct next PC
- update_bp_o  out  1  write BTB/PHT/BHR
- btb_write_pc_o, btb_write_target_o  out  DBITS  BTB entry PC and target
- pht_update_index_o  out  PHT_IDX_BITS  PHT entry to train
- br_taken_o  out  1  actual direction
- kill_o  out  1  invalidate the instruction currently in AGEX
- branch_cnt_o, mispred_cnt_o  out  CNT_BITS  statistics

## Operation
- is_br = valid_i && br_op_i != NONE && !kill_o && !done.
- Conditional ops: taken from signed or unsigned compare of rs1_i and rs2_i; target = pc_i + imm_i.
- JAL: taken=1, target = pc_i + imm_i. JALR: taken=1, target = (rs1_i + imm_i) & ~1.
- actual_next = taken ? target : pcplus_i. Mispredict = is_br && actual_next != pred_next_pc_i.
- The update happens when is_br is true: update_bp=1, btb_write_pc=pc_i, btb_write_target=target (also written when not taken), pht_update_index=pht_index_i, br_taken=taken.
- On mispredict: br_mispred=1 and br_target=actual_next.
- All outputs except counters are registered and form a single-cycle pulse group. When no event occurs, the group is cleared to 0.
- Hold-state FSM with two states:
  - IDLE → HELD when is_br && stall_i.
  - HELD → IDLE when !stall_i or !valid_i.
  - In HELD, done=1, so the held instruction is resolved and trained exactly once.
- kill_o = br_mispred_o (the registered value). The instruction in AGEX during the pulse cycle is wrong-path. It is never resolved, never trains the predictor, and is not counted.
- Counters:
  - branch_cnt increments on each is_br.
  - mispred_cnt increments on each mispredict.
  - Both wrap modulo 2^CNT_BITS.

## Timing
- Latency is 1 cycle: a branch resolved at edge N drives its outputs during cycle N+1, and FE redirects at edge N+1.
- Reset (async assert, sync deassert): all outputs 0, counters 0, FSM IDLE.
- Reset asserted mid-pulse clears the pulse immediately.
- Back-to-back branches in consecutive cycles produce consecutive pulses, unless the first mispredicted; in that case the second branch is killed.
- stall_i together with a pending pulse: the pulse still lasts exactly one cycle (FE gives redirect priority over stall).
- A held branch that mispredicted does not re-assert the redirect.
- Counters update on the same edge as the pulse registers.

## Structure
- Shared package entries: br_op encoding, DBITS, PHT_IDX_BITS, and the packed from_AGEX_to_FE field order {br_mispred, br_target, update_bp, btb_write_pc, btb_write_target, pht_update_index, br_taken} with its width macro.
- Optional sub-module br_cond_eval: combinational compare plus target computation.
- Top level contains the FSM, output registers and counters.

## Test plan
- BEQ at pc 0x100, rs1=rs2=5, imm 0x20, pred 0x104 → next cycle mispred=1, target 0x120, update_bp=1, taken=1; kill_o=1 for the following instruction; mispred_cnt=1.
- BNE at 0x200, rs1=rs2, pred 0x204 → update_bp=1, taken=0, btb_write_target=0x200+imm, mispred=0.
- JALR rs1=0x1003, imm 0 → target 0x1002; BLTU with rs1=0xFFFFFFFF, rs2=1 → not taken; BLT on the same operands → taken.
- Branch held 3 cycles by stall_i → exactly one update pulse; branch_cnt +1.
- Counters preset near wrap (force 2^32−1) plus one branch → 0.
- reset_n dropped during a pulse cycle → all outputs 0 asynchronously; after release, no stale pulse.

Source files
------------

// File: rtl/agex_branch_resolve_pkg.sv
// agex_branch_resolve shared types
// br_op encoding, hold FSM states and the AGEX->FE bundle
`ifndef FROM_AGEX_TO_FE_WIDTH
`define FROM_AGEX_TO_FE_WIDTH (3*DBITS+PHT_IDX_BITS+3)
`endif

package agex_branch_resolve_pkg;

  localparam int DBITS        = 32;
  localparam int PHT_IDX_BITS = 8;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    BEQ  = 4'd1,
    BNE  = 4'd2,
    BLT  = 4'd3,
    BGE  = 4'd4,
    BLTU = 4'd5,
    BGEU = 4'd6,
    JAL  = 4'd7,
    JALR = 4'd8
  } br_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } hold_state_e;

  localparam int FROM_AGEX_TO_FE_W =
    `FROM_AGEX_TO_FE_WIDTH;

  typedef struct packed {
    logic                    br_mispred;
    logic [DBITS-1:0]        br_target;
    logic                    update_bp;
    logic [DBITS-1:0]        btb_write_pc;
    logic [DBITS-1:0]        btb_write_target;
    logic [PHT_IDX_BITS-1:0] pht_update_index;
    logic                    br_taken;
  } from_agex_to_fe_t;

endpackage

// File: rtl/agex_branch_resolve_if.sv
// agex_branch_resolve AGEX->FE bundle
// master = AGEX resolve unit, slave = FE
interface agex_branch_resolve_if #(
  parameter int DBITS =
    agex_branch_resolve_pkg::DBITS,
  parameter int PHT_IDX_BITS =
    agex_branch_resolve_pkg::PHT_IDX_BITS,
  parameter int CNT_BITS = 32
);

  logic                    br_mispred_o;
  logic [DBITS-1:0]        br_target_o;
  logic                    update_bp_o;
  logic [DBITS-1:0]        btb_write_pc_o;
  logic [DBITS-1:0]        btb_write_target_o;
  logic [PHT_IDX_BITS-1:0] pht_update_index_o;
  logic                    br_taken_o;
  logic                    kill_o;
  logic [CNT_BITS-1:0]     branch_cnt_o;
  logic [CNT_BITS-1:0]     mispred_cnt_o;

  modport master (
    output br_mispred_o,
    output br_target_o,
    output update_bp_o,
    output btb_write_pc_o,
    output btb_write_target_o,
    output pht_update_index_o,
    output br_taken_o,
    output kill_o,
    output branch_cnt_o,
    output mispred_cnt_o
  );

  modport slave (
    input br_mispred_o,
    input br_target_o,
    input update_bp_o,
    input btb_write_pc_o,
    input btb_write_target_o,
    input pht_update_index_o,
    input br_taken_o,
    input kill_o,
    input branch_cnt_o,
    input mispred_cnt_o
  );

endinterface

// File: rtl/agex_branch_resolve_br_cond_eval.sv
// agex_branch_resolve condition evaluator
// direction compare and taken-target computation
module agex_branch_resolve_br_cond_eval #(
  parameter int DBITS = 32
) (
  input  agex_branch_resolve_pkg::br_op_e op,
  input  logic [DBITS-1:0] rs1,
  input  logic [DBITS-1:0] rs2,
  input  logic [DBITS-1:0] imm,
  input  logic [DBITS-1:0] pc,
  output logic             taken,
  output logic [DBITS-1:0] target
);
  import agex_branch_resolve_pkg::*;

  logic [DBITS-1:0] pc_tgt;
  logic [DBITS-1:0] reg_tgt;
  logic             lt_s;
  logic             lt_u;

  assign pc_tgt  = pc + imm;
  assign reg_tgt = rs1 + imm;
  assign lt_s    = $signed(rs1) < $signed(rs2);
  assign lt_u    = rs1 < rs2;

  always_comb begin
    taken  = 1'b0;
    target = pc_tgt;
    unique case (1'b1)
      (op == BEQ):  taken = (rs1 == rs2);
      (op == BNE):  taken = (rs1 != rs2);
      (op == BLT):  taken = lt_s;
      (op == BGE):  taken = !lt_s;
      (op == BLTU): taken = lt_u;
      (op == BGEU): taken = !lt_u;
      (op == JAL):  taken = 1'b1;
      (op == JALR): begin
        taken  = 1'b1;
        target = {reg_tgt[DBITS-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/agex_branch_resolve.sv
// agex_branch_resolve: AGEX branch resolution
// registered redirect/predictor-update pulses and stats
module agex_branch_resolve #(
  parameter int DBITS =
    agex_branch_resolve_pkg::DBITS,
  parameter int PHT_IDX_BITS =
    agex_branch_resolve_pkg::PHT_IDX_BITS,
  parameter int CNT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    valid_i,
  input  logic                    stall_i,
  input  logic [3:0]              br_op_i,
  input  logic [DBITS-1:0]        rs1_i,
  input  logic [DBITS-1:0]        rs2_i,
  input  logic [DBITS-1:0]        imm_i,
  input  logic [DBITS-1:0]        pc_i,
  input  logic [DBITS-1:0]        pcplus_i,
  input  logic [PHT_IDX_BITS-1:0] pht_index_i,
  input  logic [DBITS-1:0]        pred_next_pc_i,
  agex_branch_resolve_if.master   fe
);
  import agex_branch_resolve_pkg::*;

  hold_state_e      state_q;
  hold_state_e      state_d;
  br_op_e           op;
  logic             done;
  logic             is_br;
  logic             taken;
  logic             mispred;
  logic [DBITS-1:0] target;
  logic [DBITS-1:0] actual_next;

  assign op   = br_op_e'(br_op_i);
  assign done = (state_q == HELD);

  // a redirect pulse marks the current AGEX slot wrong-path
  assign fe.kill_o = fe.br_mispred_o;

  assign is_br = valid_i && (op != NONE) &&
                 !fe.kill_o && !done;

  agex_branch_resolve_br_cond_eval #(
    .DBITS (DBITS)
  ) u_cond (
    .op     (op),
    .rs1    (rs1_i),
    .rs2    (rs2_i),
    .imm    (imm_i),
    .pc     (pc_i),
    .taken  (taken),
    .target (target)
  );

  assign actual_next = taken ? target : pcplus_i;
  assign mispred = is_br &&
                   (actual_next != pred_next_pc_i);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (is_br && stall_i) state_d = HELD;
      HELD: if (!stall_i || !valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q               <= IDLE;
      fe.br_mispred_o       <= 1'b0;
      fe.br_target_o        <= '0;
      fe.update_bp_o        <= 1'b0;
      fe.btb_write_pc_o     <= '0;
      fe.btb_write_target_o <= '0;
      fe.pht_update_index_o <= '0;
      fe.br_taken_o         <= 1'b0;
      fe.branch_cnt_o       <= '0;
      fe.mispred_cnt_o      <= '0;
    end else begin
      state_q               <= state_d;
      fe.br_mispred_o       <= mispred;
      fe.br_target_o        <= mispred ? actual_next : '0;
      fe.update_bp_o        <= is_br;
      fe.btb_write_pc_o     <= is_br ? pc_i : '0;
      fe.btb_write_target_o <= is_br ? target : '0;
      fe.pht_update_index_o <= is_br ? pht_index_i : '0;
      fe.br_taken_o         <= is_br && taken;
      if (is_br)
        fe.branch_cnt_o <= fe.branch_cnt_o + 1'b1;
      if (mispred)
        fe.mispred_cnt_o <= fe.mispred_cnt_o + 1'b1;
    end
  end

endmodule
